mem_1r1w_bist: RTL

MEM_1R1W_BIST -- requirements
Module: mem_1r1w_bist

---
 rtl/mem_bist_pkg.sv | 45 ++++
 rtl/mem_bist_addr_gen.sv | 48 ++++
 rtl/mem_1r1w_bist.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and tables for the 1R1W March C- BIST engine.
// MEM_BIST_CHECKERBOARD_EN adds a second pass with an alternating pattern.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } march_elem_e;

  localparam march_elem_e LAST_ELEM = E5;

  // Per-element tables, bit n describes element En.
  localparam logic [5:0] ELEM_DOWN   = 6'b111000;
  localparam logic [5:0] ELEM_RD     = 6'b111110;
  localparam logic [5:0] ELEM_WR     = 6'b011111;
  localparam logic [5:0] ELEM_RD_INV = 6'b010100;
  localparam logic [5:0] ELEM_WR_INV = 6'b001010;

  // Pattern pairs repeated across the word; index 0 is the even bit.
  localparam logic [1:0] PAT_ZERO_PAIR = 2'b00;
  localparam logic [1:0] PAT_CB_PAIR   = 2'b01;

`ifdef MEM_BIST_CHECKERBOARD_EN
  localparam int unsigned FAIL_ELEM_W = 4;
`else
  localparam int unsigned FAIL_ELEM_W = 3;
`endif

  function automatic logic pat_bit(input logic pass, input int unsigned idx);
    logic [1:0] pair;
    pair = pass ? PAT_CB_PAIR : PAT_ZERO_PAIR;
    return pair[idx[0]];
  endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Loadable up/down address counter for the march sweeps, with last-address flag.
module mem_bist_addr_gen
  import mem_bist_pkg::*;
#(
  parameter int unsigned DEPTH  = 48,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              down_q, down_d;

  always_comb begin
    addr_d = addr_q;
    down_d = down_q;
    if (load) begin
      down_d = load_down;
      addr_d = load_down ? TOP : '0;
    end else if (step) begin
      addr_d = down_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      down_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      down_q <= down_d;
    end
  end

  always_comb begin
    addr = addr_q;
    last = down_q ? (addr_q == '0) : (addr_q == TOP);
  end

endmodule

// File: rtl/mem_1r1w_bist.sv
// March C- BIST controller for a 1R1W memory with a 1-cycle read latency.
// Define MEM_BIST_CHECKERBOARD_EN for a second pass with pattern 0101... .
module mem_1r1w_bist
  import mem_bist_pkg::*;
#(
  parameter int unsigned DEPTH  = 48,
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_W-1:0]      fail_addr,
  output logic [FAIL_ELEM_W-1:0] fail_elem,
  output logic [ADDR_W-1:0]      R0_addr,
  output logic                   R0_en,
  input  logic [WIDTH-1:0]       R0_data,
  output logic [ADDR_W-1:0]      W0_addr,
  output logic                   W0_en,
  output logic [WIDTH-1:0]       W0_data
);

  state_e                 state_q, state_d;
  march_elem_e            elem_q, elem_d, elem_nxt;
  logic                   pass_q, pass_d;
  logic                   tail_q, tail_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0]       exp_q, exp_d, pat;
  logic                   done_q, done_d, fail_q, fail_d;
  logic [ADDR_W-1:0]      fail_addr_q, fail_addr_d;
  logic [FAIL_ELEM_W-1:0] fail_elem_q, fail_elem_d;
  logic                   ag_load, ag_load_down, ag_step, ag_last;
  logic [ADDR_W-1:0]      ag_addr;
  logic                   issue, mismatch;

  mem_bist_addr_gen #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clock    (clock),
    .reset    (reset),
    .load     (ag_load),
    .load_down(ag_load_down),
    .step     (ag_step),
    .addr     (ag_addr),
    .last     (ag_last)
  );

  always_comb begin
    pat = '0;
    for (int unsigned i = 0; i < WIDTH; i++) pat[i] = pat_bit(pass_q, i);
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Read elements spend one extra tail cycle writing back the last address.
  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    pass_d   = pass_q;
    tail_d   = tail_q;
    ag_load  = 1'b0;
    ag_step  = 1'b0;
    elem_nxt = march_elem_e'(elem_q + 3'd1);
    unique case (state_q)
      S_RUN: begin
        if (mismatch) state_d = S_DONE;
        else if (!tail_q && !ag_last) ag_step = 1'b1;
        else if (!tail_q && ELEM_RD[elem_q]) tail_d = 1'b1;
        else if (elem_q != LAST_ELEM) begin
          elem_d  = elem_nxt;
          tail_d  = 1'b0;
          ag_load = 1'b1;
        end
`ifdef MEM_BIST_CHECKERBOARD_EN
        else if (!pass_q) begin
          pass_d  = 1'b1;
          elem_d  = E0;
          tail_d  = 1'b0;
          ag_load = 1'b1;
        end
`endif
        else state_d = S_DONE;
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          elem_d  = E0;
          pass_d  = 1'b0;
          tail_d  = 1'b0;
          ag_load = 1'b1;
        end
      end
    endcase
    ag_load_down = ELEM_DOWN[elem_d];
  end

  always_comb begin
    busy     = (state_q == S_RUN);
    issue    = busy && !tail_q;
    R0_en    = issue && ELEM_RD[elem_q];
    R0_addr  = R0_en ? ag_addr : '0;
    W0_en    = 1'b0;
    W0_addr  = '0;
    W0_data  = '0;
    if (issue && !ELEM_RD[elem_q]) begin
      W0_en   = 1'b1;
      W0_addr = ag_addr;
      W0_data = pat ^ {WIDTH{ELEM_WR_INV[elem_q]}};
    end else if (busy && rd_vld_q && ELEM_WR[elem_q]) begin
      W0_en   = 1'b1;
      W0_addr = rd_addr_q;
      W0_data = pat ^ {WIDTH{ELEM_WR_INV[elem_q]}};
    end
    rd_vld_d  = R0_en;
    rd_addr_d = R0_addr;
    exp_d     = R0_en ? (pat ^ {WIDTH{ELEM_RD_INV[elem_q]}}) : '0;
    mismatch  = busy && rd_vld_q && (R0_data != exp_q);

    done_d      = (state_q == S_DONE) && !start;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (!busy && start) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (mismatch) begin
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
`ifdef MEM_BIST_CHECKERBOARD_EN
      fail_elem_d = {pass_q, elem_q};
`else
      fail_elem_d = elem_q;
`endif
    end
    done      = done_q;
    fail      = fail_q;
    fail_addr = fail_addr_q;
    fail_elem = fail_elem_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      elem_q      <= E0;
      pass_q      <= 1'b0;
      tail_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      exp_q       <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      elem_q      <= elem_d;
      pass_q      <= pass_d;
      tail_q      <= tail_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      exp_q       <= exp_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

endmodule
